// File: rtl/pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_supervisor
// Description : PLL lock supervisor and staggered multi-domain reset
//               sequencer. It runs on the free-running reference clock. It
//               pulses the PLL RESET pin and qualifies the synchronised LOCK.
//               It then releases NUM_DOMAINS active-low resets in order, bit 0
//               first. On lock loss or sw_reset it re-asserts every domain
//               reset and restarts the PLL bring-up.
//
// Ports       : clk        - free-running reference clock
//               rst_n      - asynchronous active-low reset
//               pll_lock   - raw PLL LOCK (asynchronous, synchronised here)
//               sw_reset   - one-cycle request to re-sequence everything
//               pll_reset  - PLL RESET pin, active high
//               dom_rst_n  - per-domain active-low resets, bit 0 first
//               all_ready  - high only while in RUN
//               state      - 0=PLL_RST 1=WAIT_LOCK 2=RELEASE 3=RUN
//               retry_cnt  - lock-wait timeouts, saturating at 255
//               loss_cnt   - lock losses seen in RELEASE/RUN, saturating
//
// Build option: PLL_SUP_LOCK_FILTER_EN. When defined, a loss in RELEASE/RUN
//               needs GLITCH_CYCLES consecutive low lock_s samples. When
//               undefined, a single low sample is a loss.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pll_supervisor #(
   parameter int NUM_DOMAINS        = 3,
   parameter int PLL_RST_CYCLES     = 8,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RELOCK_TIMEOUT     = 65536,
   parameter int REL_DELAY          = 16,
   parameter int GLITCH_CYCLES      = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pll_lock,
   input  logic                   sw_reset,
   output logic                   pll_reset,
   output logic [NUM_DOMAINS-1:0] dom_rst_n,
   output logic                   all_ready,
   output logic [1:0]             state,
   output logic [7:0]             retry_cnt,
   output logic [7:0]             loss_cnt
);

   typedef enum logic [1:0] {
      ST_PLL_RST   = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_RELEASE   = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   localparam int c_PULSE_W   = $clog2(PLL_RST_CYCLES + 1);
   localparam int c_STABLE_W  = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int c_TIMEOUT_W = $clog2(RELOCK_TIMEOUT + 1);
   localparam int c_REL_W     = $clog2(REL_DELAY + 1);

   // Each counter compares against its terminal value minus one. The
   // transition then lands on the edge that completes the N-th cycle.
   localparam logic [c_PULSE_W-1:0]   c_PULSE_LAST   = c_PULSE_W'(PLL_RST_CYCLES - 1);
   localparam logic [c_STABLE_W-1:0]  c_STABLE_LAST  = c_STABLE_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [c_TIMEOUT_W-1:0] c_TIMEOUT_LAST = c_TIMEOUT_W'(RELOCK_TIMEOUT - 1);
   localparam logic [c_REL_W-1:0]     c_REL_LAST     = c_REL_W'(REL_DELAY - 1);

   state_t                   r_state;
   state_t                   w_state_next;
   logic [NUM_DOMAINS-1:0]   r_dom;
   logic [NUM_DOMAINS-1:0]   w_dom_next;
   logic [NUM_DOMAINS-1:0]   w_dom_shift;
   logic                     r_pll_reset;
   logic                     r_all_ready;
   logic [7:0]               r_retry_cnt;
   logic [7:0]               r_loss_cnt;
   logic                     w_retry_inc;
   logic                     w_loss_inc;
   logic                     w_restart;
   logic                     w_loss;

   logic                     r_lock_meta;
   logic                     r_lock_s;

   logic [c_PULSE_W-1:0]     r_pulse_cnt;
   logic [c_STABLE_W-1:0]    r_stable_cnt;
   logic [c_TIMEOUT_W-1:0]   r_timeout_cnt;
   logic [c_REL_W-1:0]       r_rel_cnt;

   // ------------------------------------------------------------------------
   // Two-flop synchroniser for the asynchronous LOCK input
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
      end else begin
         r_lock_meta <= pll_lock;
         r_lock_s    <= r_lock_meta;
      end
   end

   // ------------------------------------------------------------------------
   // Loss qualification in RELEASE/RUN
   // ------------------------------------------------------------------------
`ifdef PLL_SUP_LOCK_FILTER_EN
   localparam int                     c_GLITCH_W    = $clog2(GLITCH_CYCLES + 1);
   localparam logic [c_GLITCH_W-1:0]  c_GLITCH_LAST = c_GLITCH_W'(GLITCH_CYCLES - 1);

   logic [c_GLITCH_W-1:0] r_glitch_cnt;

   assign w_loss = !r_lock_s && (r_glitch_cnt == c_GLITCH_LAST);

   // The run of low samples carries across the RELEASE->RUN step. It is
   // only cleared by a high sample or by leaving for PLL_RST.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_glitch_cnt <= '0;
      end else if ((r_state == ST_RELEASE || r_state == ST_RUN) &&
                   (w_state_next != ST_PLL_RST) && !r_lock_s) begin
         r_glitch_cnt <= r_glitch_cnt + 1'b1;
      end else begin
         r_glitch_cnt <= '0;
      end
   end
`else
   logic w_unused_glitch;
   assign w_unused_glitch = ^GLITCH_CYCLES;

   assign w_loss = !r_lock_s;
`endif

   // Next release pattern: one more low-order bit set, so domains come out
   // of reset strictly in index order.
   assign w_dom_shift = (r_dom << 1) | NUM_DOMAINS'(1);

   // ------------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_dom_next   = r_dom;
      w_retry_inc  = 1'b0;
      w_loss_inc   = 1'b0;

      if (sw_reset) begin
         w_state_next = ST_PLL_RST;
         w_dom_next   = '0;
      end else begin
         case (r_state)
            ST_PLL_RST: begin
               if (r_pulse_cnt == c_PULSE_LAST) begin
                  w_state_next = ST_WAIT_LOCK;
               end
            end
            ST_WAIT_LOCK: begin
               // Reaching lock stability wins over a timeout on the same cycle.
               if (r_lock_s && (r_stable_cnt == c_STABLE_LAST)) begin
                  w_dom_next   = NUM_DOMAINS'(1);
                  w_state_next = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
               end else if (r_timeout_cnt == c_TIMEOUT_LAST) begin
                  w_state_next = ST_PLL_RST;
                  w_retry_inc  = 1'b1;
               end
            end
            ST_RELEASE: begin
               if (w_loss) begin
                  w_state_next = ST_PLL_RST;
                  w_dom_next   = '0;
                  w_loss_inc   = 1'b1;
               end else if (r_rel_cnt == c_REL_LAST) begin
                  w_dom_next = w_dom_shift;
                  if (&w_dom_shift) begin
                     w_state_next = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (w_loss) begin
                  w_state_next = ST_PLL_RST;
                  w_dom_next   = '0;
                  w_loss_inc   = 1'b1;
               end
            end
            default: begin
               w_state_next = ST_PLL_RST;
               w_dom_next   = '0;
            end
         endcase
      end
   end

   // Every phase counter restarts from zero whenever the phase is entered
   // again. This includes sw_reset while already in PLL_RST.
   assign w_restart = sw_reset || (w_state_next != r_state);

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_PLL_RST;
         r_dom       <= '0;
         r_pll_reset <= 1'b1;
         r_all_ready <= 1'b0;
         r_retry_cnt <= 8'd0;
         r_loss_cnt  <= 8'd0;
      end else begin
         r_state     <= w_state_next;
         r_dom       <= w_dom_next;
         r_pll_reset <= (w_state_next == ST_PLL_RST);
         r_all_ready <= (w_state_next == ST_RUN);
         if (w_retry_inc && (r_retry_cnt != 8'hFF)) begin
            r_retry_cnt <= r_retry_cnt + 8'd1;
         end
         if (w_loss_inc && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Phase counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pulse_cnt   <= '0;
         r_stable_cnt  <= '0;
         r_timeout_cnt <= '0;
         r_rel_cnt     <= '0;
      end else begin
         r_pulse_cnt   <= (r_state == ST_PLL_RST && !w_restart) ?
                          r_pulse_cnt + 1'b1 : '0;
         r_stable_cnt  <= (r_state == ST_WAIT_LOCK && !w_restart && r_lock_s) ?
                          r_stable_cnt + 1'b1 : '0;
         r_timeout_cnt <= (r_state == ST_WAIT_LOCK && !w_restart) ?
                          r_timeout_cnt + 1'b1 : '0;
         r_rel_cnt     <= (r_state == ST_RELEASE && !w_restart &&
                           r_rel_cnt != c_REL_LAST) ?
                          r_rel_cnt + 1'b1 : '0;
      end
   end

   assign pll_reset = r_pll_reset;
   assign dom_rst_n = r_dom;
   assign all_ready = r_all_ready;
   assign state     = r_state;
   assign retry_cnt = r_retry_cnt;
   assign loss_cnt  = r_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_supervisor
// Description : Bench for pll_supervisor. Directed bring-up, loss, retry,
//               bounce, sw_reset and glitch scenarios, then randomized lock
//               and sw_reset activity against a timing model of the rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_supervisor;

   localparam int N       = 3;
   localparam int RSTC    = 8;
   localparam int STABLE  = 16;
   localparam int TIMEOUT = 100;
   localparam int REL     = 4;
   localparam int GLITCH  = 4;
`ifdef PLL_SUP_LOCK_FILTER_EN
   localparam int LOSS_RUN = GLITCH;
`else
   localparam int LOSS_RUN = 1;
`endif

   logic         clk      = 1'b0;
   logic         rst_n    = 1'b0;
   logic         pll_lock = 1'b0;
   logic         sw_reset = 1'b0;
   logic         pll_reset;
   logic [N-1:0] dom_rst_n;
   logic         all_ready;
   logic [1:0]   state;
   logic [7:0]   retry_cnt;
   logic [7:0]   loss_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int edge_no;

   pll_supervisor #(
      .NUM_DOMAINS        (N),
      .PLL_RST_CYCLES     (RSTC),
      .LOCK_STABLE_CYCLES (STABLE),
      .RELOCK_TIMEOUT     (TIMEOUT),
      .REL_DELAY          (REL),
      .GLITCH_CYCLES      (GLITCH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pll_lock  (pll_lock),
      .sw_reset  (sw_reset),
      .pll_reset (pll_reset),
      .dom_rst_n (dom_rst_n),
      .all_ready (all_ready),
      .state     (state),
      .retry_cnt (retry_cnt),
      .loss_cnt  (loss_cnt)
   );

   always #5 clk = ~clk;

   // Edge 1 is the first rising edge after rst_n is released.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_no <= 0;
      else        edge_no <= edge_no + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d, t=%0t)",
                  name, act, exp, edge_no, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: the phase, the cycles spent in it, and run lengths
   // ------------------------------------------------------------------------
   int   m_phase;   // 0=PLL_RST 1=WAIT_LOCK 2=RELEASE 3=RUN
   int   m_t;       // edges since the phase was entered
   int   m_stable;  // consecutive high lock_s samples while waiting
   int   m_low;     // consecutive low lock_s samples in RELEASE/RUN
   int   m_retry;
   int   m_loss;
   logic m_q1;      // raw lock seen one edge ago
   logic m_ls;      // raw lock seen two edges ago (= synchronised lock)

   task automatic m_enter(input int p);
      m_phase  = p;
      m_t      = 0;
      m_stable = 0;
      m_low    = 0;
   endtask

   task automatic m_reset();
      m_enter(0);
      m_retry = 0;
      m_loss  = 0;
      m_q1    = 1'b0;
      m_ls    = 1'b0;
   endtask

   task automatic m_step();
      logic ls;
      ls   = m_ls;
      m_ls = m_q1;
      m_q1 = pll_lock;
      if (sw_reset) begin
         m_enter(0);
      end else if (m_phase == 0) begin
         m_t++;
         if (m_t == RSTC) m_enter(1);
      end else if (m_phase == 1) begin
         m_t++;
         m_stable = ls ? m_stable + 1 : 0;
         if (m_stable == STABLE) begin
            m_enter((N == 1) ? 3 : 2);
         end else if (m_t == TIMEOUT) begin
            if (m_retry < 255) m_retry++;
            m_enter(0);
         end
      end else begin
         m_low = ls ? 0 : m_low + 1;
         if (m_low >= LOSS_RUN) begin
            if (m_loss < 255) m_loss++;
            m_enter(0);
         end else if (m_phase == 2) begin
            m_t++;
            if (m_t == (N - 1) * REL) m_phase = 3;
         end
      end
   endtask

   function automatic logic [N-1:0] m_dom();
      if (m_phase == 3) return '1;
      if (m_phase == 2) return N'((1 << (m_t / REL + 1)) - 1);
      return '0;
   endfunction

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else        m_step();
      end
   end

   // Cycle-by-cycle comparison against the model
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rst_n) begin
            chk("cyc_pll_reset", pll_reset, (m_phase == 0));
            chk("cyc_dom_rst_n", dom_rst_n, m_dom());
            chk("cyc_all_ready", all_ready, (m_phase == 3));
            chk("cyc_state",     state,     m_phase);
            chk("cyc_retry_cnt", retry_cnt, m_retry);
            chk("cyc_loss_cnt",  loss_cnt,  m_loss);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic go_to_edge(input int n);
      while (edge_no < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic lock_val);
      @(negedge clk);
      rst_n    = 1'b0;
      pll_lock = lock_val;
      sw_reset = 1'b0;
      #1;
      chk("rst_pll_reset", pll_reset, 1);
      chk("rst_dom_rst_n", dom_rst_n, 0);
      chk("rst_all_ready", all_ready, 0);
      chk("rst_state",     state,     0);
      chk("rst_retry_cnt", retry_cnt, 0);
      chk("rst_loss_cnt",  loss_cnt,  0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic v;
      int   len;

      // Nominal bring-up, then a lock loss in RUN and recovery
      do_reset(1'b1);
      go_to_edge(7);  chk("nom_pll_reset_e7",  pll_reset, 1);
      go_to_edge(8);  chk("nom_pll_reset_e8",  pll_reset, 0);
                      chk("nom_state_e8",      state,     1);
      go_to_edge(23); chk("nom_dom_e23",       dom_rst_n, 3'b000);
      go_to_edge(24); chk("nom_dom_e24",       dom_rst_n, 3'b001);
                      chk("nom_state_e24",     state,     2);
      go_to_edge(27); chk("nom_dom_e27",       dom_rst_n, 3'b001);
      go_to_edge(28); chk("nom_dom_e28",       dom_rst_n, 3'b011);
      go_to_edge(31); chk("nom_ready_e31",     all_ready, 0);
      go_to_edge(32); chk("nom_dom_e32",       dom_rst_n, 3'b111);
                      chk("nom_ready_e32",     all_ready, 1);
                      chk("nom_state_e32",     state,     3);
      go_to_edge(40);
      @(negedge clk); pll_lock = 1'b0;
      go_to_edge(42); chk("loss_dom_e42",      dom_rst_n, 3'b111);
      go_to_edge(43); chk("loss_dom_e43",      dom_rst_n, 3'b000);
                      chk("loss_cnt_e43",      loss_cnt,  1);
                      chk("loss_state_e43",    state,     0);
                      chk("loss_ready_e43",    all_ready, 0);
      @(negedge clk); pll_lock = 1'b1;
      go_to_edge(50); chk("loss_pll_reset_e50", pll_reset, 1);
      go_to_edge(51); chk("loss_pll_reset_e51", pll_reset, 0);
      go_to_edge(74); chk("loss_dom_e74",      dom_rst_n, 3'b011);
      go_to_edge(75); chk("loss_dom_e75",      dom_rst_n, 3'b111);
                      chk("loss_ready_e75",    all_ready, 1);

      // sw_reset while only domain 0 is released
      do_reset(1'b1);
      go_to_edge(25); chk("sw_dom_e25",        dom_rst_n, 3'b001);
      @(negedge clk); sw_reset = 1'b1;
      go_to_edge(26); chk("sw_dom_e26",        dom_rst_n, 3'b000);
                      chk("sw_state_e26",      state,     0);
                      chk("sw_loss_e26",       loss_cnt,  0);
      @(negedge clk); sw_reset = 1'b0;
      go_to_edge(57); chk("sw_ready_e57",      all_ready, 0);
      go_to_edge(58); chk("sw_dom_e58",        dom_rst_n, 3'b111);
                      chk("sw_state_e58",      state,     3);

      // No lock at all: periodic PLL retries
      do_reset(1'b0);
      go_to_edge(8);   chk("nol_pll_reset_e8",   pll_reset, 0);
      go_to_edge(107); chk("nol_retry_e107",     retry_cnt, 0);
      go_to_edge(108); chk("nol_pll_reset_e108", pll_reset, 1);
                       chk("nol_retry_e108",     retry_cnt, 1);
      go_to_edge(116); chk("nol_pll_reset_e116", pll_reset, 0);
      go_to_edge(324); chk("nol_retry_e324",     retry_cnt, 3);
                       chk("nol_pll_reset_e324", pll_reset, 1);
                       chk("nol_dom_e324",       dom_rst_n, 3'b000);

      // One-cycle bounce after 10 stable cycles in WAIT_LOCK
      do_reset(1'b1);
      go_to_edge(16);
      @(negedge clk); pll_lock = 1'b0;
      go_to_edge(17);
      @(negedge clk); pll_lock = 1'b1;
      go_to_edge(34); chk("bnc_dom_e34",       dom_rst_n, 3'b000);
      go_to_edge(35); chk("bnc_dom_e35",       dom_rst_n, 3'b001);

      // Two-cycle glitch in RUN
      do_reset(1'b1);
      go_to_edge(40);
      @(negedge clk); pll_lock = 1'b0;
      go_to_edge(42);
      @(negedge clk); pll_lock = 1'b1;
      go_to_edge(46);
`ifdef PLL_SUP_LOCK_FILTER_EN
      chk("glt_loss_cnt", loss_cnt,  0);
      chk("glt_dom",      dom_rst_n, 3'b111);
`else
      chk("glt_loss_cnt", loss_cnt,  1);
      chk("glt_dom",      dom_rst_n, 3'b000);
`endif

      // Randomized lock segments with occasional sw_reset
      do_reset(1'b1);
      while (edge_no < 5000) begin
         v   = ($urandom_range(0, 3) != 0);
         len = $urandom_range(1, 120);
         repeat (len) begin
            @(negedge clk);
            pll_lock = v;
            sw_reset = ($urandom_range(0, 299) == 0);
         end
      end
      @(negedge clk);
      sw_reset = 1'b0;
      pll_lock = 1'b1;
      repeat (4) @(posedge clk);
      #3;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pll_supervisor.md
# pll_supervisor

Parametrised PLL lock supervisor and multi-domain reset sequencer. It runs on the free-running board reference clock (27 MHz crystal), not on the PLL output. It drives the rPLL `RESET` pin, qualifies `LOCK`, and releases `NUM_DOMAINS` reset outputs in staggered order once lock is stable. On lock loss or a software request it re-asserts all domain resets and re-runs the PLL bring-up, counting retries and losses.

## Interface
Parameters:
- `NUM_DOMAINS`, 3: number of sequenced reset outputs, range 1..16.
- `PLL_RST_CYCLES`, 8: length of each `pll_reset` pulse in clk cycles, ≥1.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronised lock-high cycles required before release, ≥1.
- `RELOCK_TIMEOUT`, 65536: maximum cycles in WAIT_LOCK before a PLL retry, must exceed `LOCK_STABLE_CYCLES`.
- `REL_DELAY`, 16: gap in cycles between successive domain releases, ≥1.
- `GLITCH_CYCLES`, 4: lock-low filter length. Used only with the configuration macro defined.

Ports:
- `clk`  in  1  free-running reference clock. One clock domain only.
- `rst_n`  in  1  asynchronous active-low reset.
- `pll_lock`  in  1  raw PLL LOCK, asynchronous. Passes through a 2-flop synchroniser to produce `lock_s`.
- `sw_reset`  in  1  synchronous one-cycle request to re-sequence everything.
- `pll_reset`  out  1  to rPLL RESET, active high.
- `dom_rst_n`  out  NUM_DOMAINS  per-domain active-low resets. Bit 0 is released first.
- `all_ready`  out  1  high only in RUN.
- `state`  out  2  encoding 0=PLL_RST, 1=WAIT_LOCK, 2=RELEASE, 3=RUN.
- `retry_cnt`  out  8  WAIT_LOCK timeouts, saturating at 255.
- `loss_cnt`  out  8  lock losses detected in RELEASE/RUN, saturating at 255.

## Operation
- Reset state while `rst_n`=0: state=PLL_RST, `pll_reset`=1, `dom_rst_n`=0, `all_ready`=0, counters=0, synchroniser=0.
- **PLL_RST:** `pll_reset`=1 for exactly `PLL_RST_CYCLES` cycles, then go to WAIT_LOCK. All domains are held in reset.
- **WAIT_LOCK:** `pll_reset`=0.
  - The stable counter increments while `lock_s`=1 and clears when `lock_s`=0.
  - The timeout counter increments every cycle.
  - Stable counter reaches `LOCK_STABLE_CYCLES`: go to RELEASE, or to RUN if `NUM_DOMAINS`=1.
  - Timeout counter reaches `RELOCK_TIMEOUT` first: go to PLL_RST and increment `retry_cnt`.
  - If both conditions occur on the same cycle, RELEASE wins.
- **RELEASE:**
  - `dom_rst_n[0]` rises on the edge that enters RELEASE.
  - `dom_rst_n[i]` rises `i*REL_DELAY` cycles later.
  - The edge that releases bit `NUM_DOMAINS-1` also enters RUN and sets `all_ready`=1.
- **RUN:** holding state. All outputs are steady.
- **Lock loss** (the loss condition below, in RELEASE or RUN):
  - On the next edge, all `dom_rst_n` go to 0 simultaneously and `all_ready` goes to 0.
  - `loss_cnt` increments and the state goes to PLL_RST.
- **`sw_reset`=1** in any state: same action as lock loss, but without incrementing `loss_cnt`. It has priority over every other transition. In PLL_RST it restarts the pulse count.
- Domain resets are never released out of order. Once a reset is asserted, it never deasserts without passing through WAIT_LOCK again.

## Timing
- Lock synchroniser latency is 2 cycles. A `pll_lock` edge is visible in `lock_s` at edge 2.
- Lock-loss response: on the edge after `lock_s` is first seen low (unfiltered), so 3 edges from the raw `pll_lock` fall.
- All outputs are registered, with no combinational input-to-output paths.
- Counters use widths of `$clog2(param+1)` and compare for equality. None of them wraps.
- Deasserting `rst_n` mid-sequence has no special handling. Asserting it mid-sequence forces reset values asynchronously.

## Configuration
- `PLL_SUP_LOCK_FILTER_EN` defined: in RELEASE/RUN, the loss condition requires `lock_s`=0 for `GLITCH_CYCLES` consecutive cycles. Shorter low pulses are ignored. Response is `GLITCH_CYCLES`+2 edges after the raw fall.
- Macro undefined: a single `lock_s` low cycle is a loss condition. `GLITCH_CYCLES` is unused.
- WAIT_LOCK behaviour is identical in both builds.

## Test plan
Bench parameters: `NUM_DOMAINS`=3, `PLL_RST_CYCLES`=8, `LOCK_STABLE_CYCLES`=16, `REL_DELAY`=4, `RELOCK_TIMEOUT`=100. Edge 1 is the first edge after `rst_n` rises.

- **Nominal bring-up:** `pll_lock`=1 throughout → `pll_reset` falls at edge 8; `dom_rst_n` goes 001 at edge 24, 011 at 28, 111 at 32; `all_ready`=1 at 32; `state`=3.
- **No lock:** `pll_lock`=0 → `pll_reset` pulses of 8 cycles every 108 cycles; `retry_cnt` reaches 3 after the 3rd timeout; `dom_rst_n` stays 000.
- **Bounce during WAIT_LOCK:** `pll_lock` low for 1 cycle after 10 stable cycles → stable count restarts; release delayed by 11 cycles versus the nominal case.
- **Loss in RUN:** drop `pll_lock` → `dom_rst_n`=000 three edges after the fall; `loss_cnt`=1; `pll_reset`=1 for 8 cycles; on restore, full re-sequence.
- **sw_reset during RELEASE** (`dom_rst_n`=001) → next edge `dom_rst_n`=000, `state`=0, `loss_cnt` unchanged; re-sequence completes normally.
- **Filter (macro defined, `GLITCH_CYCLES`=4):** 2-cycle lock glitch in RUN → no reset, `loss_cnt`=0. Same stimulus with the macro undefined → resets asserted, `loss_cnt`=1.
